param_memory_loader: RTL and testbench
======================================

Name: param_memory_loader

Overview:
- Parametrised M x N register memory with two write paths: random-access writes and a streaming sequential loader with valid/ready handshake.
- Also provides a registered read port, a multi-cycle sequential clear, and a flat all-entries output bus.
- Feeds weight/configuration storage to downstream compute blocks. Next generation of the fixed 66 x 8 configuration memory, adding burst load, handshake, clear and error reporting.

Parameters:
- M, 66, number of entries (M >= 2)
- N, 8, entry width in bits
- AW, $clog2(M) (7 at default), address/pointer width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- data_in  input  N  write data, shared by the random and stream paths
- addr  input  AW  random-write address
- write_enable  input  1  random-write strobe
- burst_start  input  1  start a sequential load at entry 0
- s_valid  input  1  stream beat valid
- s_ready  output  1  stream beat ready
- clear  input  1  start a sequential clear of all entries
- rd_en  input  1  read request
- rd_addr  input  AW  read address
- data_out  output  N  registered read data
- rd_valid  output  1  data_out valid strobe
- wr_ptr  output  AW  current stream/clear pointer
- load_done  output  1  all M entries loaded by the stream path
- busy  output  1  clear in progress
- addr_err  output  1  sticky out-of-range access flag
- all_data_out  output  M*N  entry j on bits [j*N +: N]

Behaviour:
- Reset (asynchronous): all entries 0, state IDLE, wr_ptr 0, data_out 0, rd_valid 0, load_done 0, busy 0, addr_err 0, s_ready 0.
- FSM states: IDLE, LOAD, FULL, CLEAR. Command priority in any cycle: clear > burst_start > stream beat > write_enable.
- IDLE:
  - burst_start -> LOAD; wr_ptr <= 0; load_done <= 0.
  - write_enable with addr < M: mem[addr] <= data_in at the edge.
- LOAD:
  - s_ready = 1 (combinational from state, independent of s_valid).
  - Beat accepted when s_valid && s_ready: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr + 1.
  - Beat accepted at wr_ptr == M-1: wr_ptr wraps to 0; load_done <= 1; next state FULL.
  - write_enable is ignored.
  - burst_start restarts wr_ptr at 0, discards that cycle's beat, stays in LOAD.
- FULL:
  - s_ready = 0; load_done held at 1.
  - Random writes allowed exactly as in IDLE; load_done stays 1.
  - burst_start -> LOAD, load_done <= 0.
- CLEAR:
  - Entered from any state on clear. That edge: wr_ptr <= 0, busy <= 1, load_done <= 0, addr_err <= 0.
  - Each cycle in CLEAR: mem[wr_ptr] <= 0; wr_ptr++.
  - After the edge that clears entry M-1: wr_ptr <= 0, busy <= 0, next state IDLE. A full clear takes exactly M cycles in CLEAR.
  - clear asserted while in CLEAR restarts at entry 0.
  - write_enable, burst_start and s_valid are ignored; s_ready = 0.
- Read path, 1-cycle latency:
  - rd_en sampled at edge k: data_out <= mem[rd_addr] (read-before-write, so a same-cycle write to the same address returns the old value); rd_valid <= 1 for one cycle.
  - rd_en low: rd_valid <= 0 and data_out holds.
  - Reads are allowed in every state, including CLEAR.
- Out of range (rd_addr >= M, or addr >= M with an honoured write_enable):
  - No memory change.
  - Read returns data_out <= 0 with rd_valid still pulsed.
  - addr_err <= 1 (sticky until reset or clear).
- all_data_out is combinational from the array and reflects a write in the cycle after its edge.
- Reset asserted mid-load or mid-clear aborts immediately to the reset values.

Test Plan:
- Reset, then rd_en at addresses 0 and 65 -> rd_valid pulses one cycle after each request, data_out = 0x00, all_data_out = 0.
- burst_start, then 66 beats with values 0x00..0x41, s_valid toggled every other cycle -> each entry j = j; load_done rises on the edge after beat 66; state FULL; s_ready = 0; wr_ptr = 0.
- In FULL: write_enable addr 5 = 0xAA plus rd_en rd_addr 5 in the same cycle -> data_out = 0x05; next read returns 0xAA; load_done stays 1.
- write_enable addr 70 = 0x11 -> memory unchanged, addr_err = 1; rd_en rd_addr 80 -> data_out 0x00, rd_valid 1.
- After load, pulse clear -> busy high for exactly 66 cycles; all_data_out = 0 afterwards; addr_err and load_done = 0; state IDLE. A second clear pulsed at cycle 30 restarts wr_ptr at 0, so busy lasts 66 cycles from that pulse.
- Assert reset after 20 stream beats -> all outputs at reset values; s_ready 0; a subsequent burst_start reloads from entry 0.

Source files
------------

// File: rtl/param_memory_loader_if.sv
// rtl/param_memory_loader_if.sv - bus bundle for the parameter memory loader
//
// Groups every non-clock/reset signal of param_memory_loader.
//   master : drives write/stream/clear/read requests, observes status and data
//   slave  : the memory itself
// Signals:
//   data_in, addr, write_enable      random-write path (data_in shared with stream)
//   burst_start, s_valid, s_ready    sequential stream loader handshake
//   clear                            sequential clear request
//   rd_en, rd_addr, data_out, rd_valid  registered read port
//   wr_ptr, load_done, busy, addr_err   status
//   all_data_out                     flat view of every entry, entry j at [j*N +: N]
interface param_memory_loader_if #(
  parameter int M  = 66,
  parameter int N  = 8,
  parameter int AW = $clog2(M)
) ();
  logic [N-1:0]   data_in;
  logic [AW-1:0]  addr;
  logic           write_enable;
  logic           burst_start;
  logic           s_valid;
  logic           s_ready;
  logic           clear;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [N-1:0]   data_out;
  logic           rd_valid;
  logic [AW-1:0]  wr_ptr;
  logic           load_done;
  logic           busy;
  logic           addr_err;
  logic [M*N-1:0] all_data_out;

  modport master (
    output data_in, addr, write_enable, burst_start, s_valid, clear, rd_en, rd_addr,
    input  s_ready, data_out, rd_valid, wr_ptr, load_done, busy, addr_err, all_data_out
  );

  modport slave (
    input  data_in, addr, write_enable, burst_start, s_valid, clear, rd_en, rd_addr,
    output s_ready, data_out, rd_valid, wr_ptr, load_done, busy, addr_err, all_data_out
  );
endinterface

// File: rtl/param_memory_loader.sv
// rtl/param_memory_loader.sv - M x N register memory with random, stream and clear write paths
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, returns everything to zero / IDLE
//   bus    param_memory_loader_if.slave
//            random writes   : write_enable, addr, data_in
//            stream loader   : burst_start, s_valid, s_ready, data_in, wr_ptr, load_done
//            clear           : clear, busy, wr_ptr
//            read port       : rd_en, rd_addr -> data_out, rd_valid (1-cycle latency)
//            error           : addr_err (sticky until reset or clear)
//            flat view       : all_data_out
module param_memory_loader #(
  parameter int M  = 66,
  parameter int N  = 8,
  parameter int AW = $clog2(M)
) (
  input  logic                 clk,
  input  logic                 reset,
  param_memory_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FULL  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // One extra bit so the bound is representable even when M is a power of two.
  localparam logic [AW:0]   DEPTH = (AW+1)'(M);
  localparam logic [AW-1:0] LAST  = AW'(M - 1);

  state_t         state, state_next;
  logic [AW-1:0]  ptr, ptr_next;
  logic           load_done, load_done_next;
  logic           busy, busy_next;
  logic           addr_err, addr_err_next;

  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [N-1:0]   mem_wdata;

  logic [N-1:0]   mem [M];
  logic [N-1:0]   data_out;
  logic           rd_valid;

  logic           wr_in_range;
  logic           rd_in_range;

  assign wr_in_range = ({1'b0, bus.addr}    < DEPTH);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH);

  // State and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      load_done <= 1'b0;
      busy      <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      load_done <= load_done_next;
      busy      <= busy_next;
      addr_err  <= addr_err_next;
    end
  end

  // Next-state and write-port decode. Priority: clear > burst_start > beat > write_enable.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    load_done_next = load_done;
    busy_next      = busy;
    addr_err_next  = addr_err;
    mem_we         = 1'b0;
    mem_waddr      = ptr;
    mem_wdata      = '0;

    if (bus.clear) begin
      // Clear also wins over an out-of-range read in the same cycle: the flag is wiped.
      state_next     = CLEAR;
      ptr_next       = '0;
      busy_next      = 1'b1;
      load_done_next = 1'b0;
      addr_err_next  = 1'b0;
    end else begin
      case (state)
        IDLE, FULL: begin
          if (bus.burst_start) begin
            state_next     = LOAD;
            ptr_next       = '0;
            load_done_next = 1'b0;
          end else if (bus.write_enable) begin
            if (wr_in_range) begin
              mem_we    = 1'b1;
              mem_waddr = bus.addr;
              mem_wdata = bus.data_in;
            end else begin
              addr_err_next = 1'b1;
            end
          end
        end

        LOAD: begin
          if (bus.burst_start) begin
            // Restart: the beat presented this cycle is dropped.
            ptr_next = '0;
          end else if (bus.s_valid) begin
            mem_we    = 1'b1;
            mem_waddr = ptr;
            mem_wdata = bus.data_in;
            if (ptr == LAST) begin
              ptr_next       = '0;
              load_done_next = 1'b1;
              state_next     = FULL;
            end else begin
              ptr_next = ptr + AW'(1);
            end
          end
        end

        CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = ptr;
          mem_wdata = '0;
          if (ptr == LAST) begin
            ptr_next   = '0;
            busy_next  = 1'b0;
            state_next = IDLE;
          end else begin
            ptr_next = ptr + AW'(1);
          end
        end

        default: state_next = IDLE;
      endcase

      if (bus.rd_en && !rd_in_range) begin
        addr_err_next = 1'b1;
      end
    end
  end

  // Storage array: single write port shared by all three write paths.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < M; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read; samples the array before this edge's write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        data_out <= rd_in_range ? mem[bus.rd_addr] : '0;
      end
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_flat
    assign bus.all_data_out[j*N +: N] = mem[j];
  end

  assign bus.s_ready   = (state == LOAD);
  assign bus.data_out  = data_out;
  assign bus.rd_valid  = rd_valid;
  assign bus.wr_ptr    = ptr;
  assign bus.load_done = load_done;
  assign bus.busy      = busy;
  assign bus.addr_err  = addr_err;

endmodule

// File: tb/tb_param_memory_loader.sv
// tb/tb_param_memory_loader.sv - self-checking bench for param_memory_loader
module tb_param_memory_loader;
  localparam int M  = 66;
  localparam int N  = 8;
  localparam int AW = 7;

  logic clk;
  logic reset;

  param_memory_loader_if #(.M(M), .N(N), .AW(AW)) bus ();

  param_memory_loader #(.M(M), .N(N), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [N-1:0]  wdata;
    logic          rd;
    logic [AW-1:0] raddr;
    logic [N-1:0]  exp_dout;
    logic          exp_rvalid;
    logic          exp_err;
    logic          exp_done;
  } vec_t;

  vec_t         vecs [8];
  logic [N-1:0] model [M];
  int           tests;
  int           fails;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int j = 0; j < M; j++) begin
      if (bus.all_data_out[j*N +: N] !== model[j]) begin
        bad++;
        if (first < 0) first = j;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d entries differ, first entry %0d got 0x%0h expected 0x%0h",
               name, bad, first, bus.all_data_out[first*N +: N], model[first]);
    end
  endtask

  task automatic clear_model();
    for (int j = 0; j < M; j++) model[j] = '0;
  endtask

  initial begin
    int cnt;
    tests = 0;
    fails = 0;

    //            we    addr    wdata  rd    raddr   dout   rv    err   done
    vecs[0] = '{1'b1, 7'd5,  8'hAA, 1'b1, 7'd5,  8'h05, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 7'd0,  8'h00, 1'b1, 7'd5,  8'hAA, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 7'd70, 8'h11, 1'b0, 7'd0,  8'hAA, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 7'd0,  8'h00, 1'b1, 7'd80, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 7'd0,  8'h00, 1'b1, 7'd65, 8'h41, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 7'd65, 8'h77, 1'b1, 7'd65, 8'h41, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 7'd0,  8'h00, 1'b1, 7'd65, 8'h77, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 7'd0,  8'h00, 1'b0, 7'd0,  8'h77, 1'b0, 1'b1, 1'b1};

    clear_model();
    reset            = 1'b1;
    bus.data_in      = '0;
    bus.addr         = '0;
    bus.write_enable = 1'b0;
    bus.burst_start  = 1'b0;
    bus.s_valid      = 1'b0;
    bus.clear        = 1'b0;
    bus.rd_en        = 1'b0;
    bus.rd_addr      = '0;

    // Reset state
    tick();
    tick();
    chk("reset data_out", 32'(bus.data_out), 32'h0);
    chk("reset rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("reset s_ready", 32'(bus.s_ready), 32'h0);
    chk("reset load_done", 32'(bus.load_done), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset addr_err", 32'(bus.addr_err), 32'h0);
    chk("reset wr_ptr", 32'(bus.wr_ptr), 32'h0);
    chk_all("reset all_data_out");
    reset = 1'b0;

    // Reads of the empty memory at both ends
    bus.rd_en = 1'b1; bus.rd_addr = 7'd0;
    tick();
    chk("rd0 rd_valid", 32'(bus.rd_valid), 32'h1);
    chk("rd0 data_out", 32'(bus.data_out), 32'h0);
    bus.rd_addr = 7'd65;
    tick();
    chk("rd65 rd_valid", 32'(bus.rd_valid), 32'h1);
    chk("rd65 data_out", 32'(bus.data_out), 32'h0);
    bus.rd_en = 1'b0;
    tick();
    chk("rd_valid drops", 32'(bus.rd_valid), 32'h0);

    // Full stream load, s_valid toggled every other cycle
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    chk("load s_ready", 32'(bus.s_ready), 32'h1);
    chk("load wr_ptr start", 32'(bus.wr_ptr), 32'h0);
    for (int j = 0; j < M; j++) begin
      if (j == M - 1) begin
        chk("before last beat wr_ptr", 32'(bus.wr_ptr), 32'(M - 1));
        chk("before last beat load_done", 32'(bus.load_done), 32'h0);
      end
      bus.s_valid = 1'b1;
      bus.data_in = N'(j);
      model[j] = N'(j);
      tick();
      bus.s_valid = 1'b0;
      if (j == M - 1) break;
      if (j == 10) begin
        // random write while loading must be ignored
        bus.write_enable = 1'b1; bus.addr = 7'd3; bus.data_in = 8'hEE;
      end
      tick();
      bus.write_enable = 1'b0;
    end
    chk("after load load_done", 32'(bus.load_done), 32'h1);
    chk("after load s_ready", 32'(bus.s_ready), 32'h0);
    chk("after load wr_ptr", 32'(bus.wr_ptr), 32'h0);
    chk("after load addr_err", 32'(bus.addr_err), 32'h0);
    chk_all("after load contents");

    // Table-driven random writes / reads in FULL
    for (int i = 0; i < 8; i++) begin
      bus.write_enable = vecs[i].we;
      bus.addr         = vecs[i].addr;
      bus.data_in      = vecs[i].wdata;
      bus.rd_en        = vecs[i].rd;
      bus.rd_addr      = vecs[i].raddr;
      tick();
      if (vecs[i].we && (int'(vecs[i].addr) < M)) model[vecs[i].addr] = vecs[i].wdata;
      chk($sformatf("vec%0d data_out", i), 32'(bus.data_out), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].exp_rvalid));
      chk($sformatf("vec%0d addr_err", i), 32'(bus.addr_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d load_done", i), 32'(bus.load_done), 32'(vecs[i].exp_done));
    end
    bus.write_enable = 1'b0;
    bus.rd_en = 1'b0;
    chk_all("after table contents");

    // Sequential clear, with a read of a not-yet-cleared entry along the way
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 200) begin
      cnt++;
      bus.rd_en = (cnt == 10);
      bus.rd_addr = 7'd65;
      tick();
      if (cnt == 10) chk("read during clear", 32'(bus.data_out), 32'h77);
    end
    bus.rd_en = 1'b0;
    clear_model();
    chk("clear busy cycles", 32'(cnt), 32'(M));
    chk("after clear addr_err", 32'(bus.addr_err), 32'h0);
    chk("after clear load_done", 32'(bus.load_done), 32'h0);
    chk("after clear wr_ptr", 32'(bus.wr_ptr), 32'h0);
    chk("after clear s_ready", 32'(bus.s_ready), 32'h0);
    chk_all("after clear contents");

    // Clear restarted at cycle 30, burst_start held meanwhile must be ignored
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.burst_start = 1'b1;
    repeat (29) tick();
    bus.burst_start = 1'b0;
    chk("mid clear wr_ptr", 32'(bus.wr_ptr), 32'd29);
    chk("mid clear s_ready", 32'(bus.s_ready), 32'h0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("restart wr_ptr", 32'(bus.wr_ptr), 32'h0);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("restart busy cycles", 32'(cnt), 32'(M));
    chk("restart end s_ready", 32'(bus.s_ready), 32'h0);

    // Reset in the middle of a stream load
    bus.write_enable = 1'b1; bus.addr = 7'd40; bus.data_in = 8'h12;
    tick();
    bus.write_enable = 1'b0;
    model[40] = 8'h12;
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    bus.s_valid = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.data_in = N'(8'h80 + j);
      model[j] = N'(8'h80 + j);
      tick();
    end
    bus.s_valid = 1'b0;
    chk("20 beats wr_ptr", 32'(bus.wr_ptr), 32'd20);
    chk_all("20 beats contents");
    #3;
    reset = 1'b1;
    #1;
    clear_model();
    chk("abort s_ready", 32'(bus.s_ready), 32'h0);
    chk("abort wr_ptr", 32'(bus.wr_ptr), 32'h0);
    chk("abort data_out", 32'(bus.data_out), 32'h0);
    chk("abort load_done", 32'(bus.load_done), 32'h0);
    chk_all("abort contents");
    tick();
    reset = 1'b0;

    // Reload from entry 0, with a burst_start restart that drops its beat
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    bus.s_valid = 1'b1;
    bus.data_in = 8'hC0; tick();
    bus.data_in = 8'hC1; tick();
    bus.burst_start = 1'b1; bus.data_in = 8'hEE;
    tick();
    bus.burst_start = 1'b0;
    chk("burst restart wr_ptr", 32'(bus.wr_ptr), 32'h0);
    bus.data_in = 8'hC2; tick();
    bus.data_in = 8'hC3; tick();
    bus.data_in = 8'hC4; tick();
    bus.s_valid = 1'b0;
    model[0] = 8'hC2; model[1] = 8'hC3; model[2] = 8'hC4;
    chk("reload wr_ptr", 32'(bus.wr_ptr), 32'd3);
    chk("reload s_ready", 32'(bus.s_ready), 32'h1);
    chk_all("reload contents");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
